// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Owns the PC and issues word requests to a one-cycle-latency instruction memory.
// Returned words are queued with their PCs for decode, which drains the queue
// through a valid/ready handshake. Execute redirects the stream with a one-cycle pulse.
// Optional build macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect halts fetch
// and pulses misalign_err. Without it, the low target bits are dropped.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        misalign_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          halted;
    logic          pop;
    logic          push;
    logic [CW:0]   occupancy;
    logic [31:0]   target_pc;

    // The target is always word aligned. A misaligned target is caught
    // separately when the check is built in.
    assign target_pc = {redirect_pc[31:2], 2'b00};

    assign instr_valid = (count != '0);
    assign instr       = q_instr[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];
    assign imem_addr   = pc;

    assign pop  = instr_valid & instr_ready & ~redirect_valid;
    assign push = inflight & ~redirect_valid;

    // A slot already held by an outstanding response counts as used. A slot
    // freed by this cycle's pop can be reused immediately, which gives
    // 1/cycle even at DEPTH=2.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign imem_req  = ~rst & ~redirect_valid & ~halted & (occupancy < (CW+1)'(DEPTH));

`ifdef FETCH_MISALIGN_CHECK_EN
    logic target_bad;
    assign target_bad = (redirect_pc[1:0] != 2'b00);

    // Halt on a misaligned redirect. Only a later aligned redirect resumes
    // fetch. The error flag pulses for one cycle after the redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid & target_bad;
            if (redirect_valid)
                halted <= target_bad;
        end
    end
`else
    logic pc_lsb_unused;
    assign pc_lsb_unused = ^redirect_pc[1:0];
    assign halted        = 1'b0;
    assign misalign_err  = 1'b0;
`endif

    // PC, outstanding-request tracking and queue bookkeeping. A redirect
    // overrides everything else in its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            pc       <= target_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (imem_req) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
            inflight <= imem_req;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage. It is cleared on reset so that the head reads as zero
    // until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized bench for fetch_unit against a queue-based model.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misalign_err;

    logic        req2;
    logic [31:0] addr2;
    logic [31:0] rdata2 = 32'h0;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        mis2;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .misalign_err(misalign_err));

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(rdata2), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(valid2), .instr(instr2), .instr_pc(pc2),
        .instr_ready(instr_ready), .misalign_err(mis2));

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    int          n_err = 0;
    int          n_checks = 0;
    ent_t        q[$];
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_mis;
    logic        mem_pend;
    logic [31:0] mem_addr;

    logic        o_req, o_valid, o_mis, o_req2;
    logic [31:0] o_addr, o_instr, o_pc, o_addr2;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_infl    = 1'b0;
        m_infl_pc = 32'h0;
        m_pc      = 32'h0;
        m_halt    = 1'b0;
        m_mis     = 1'b0;
        mem_pend  = 1'b0;
        mem_addr  = 32'h0;
    endtask

    // Assert reset mid-cycle, check the immediate drop and the reset values,
    // then release reset so that the next step() is cycle 0.
    task automatic do_reset();
        #2 rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        imem_rdata     = 32'($urandom);
        #1;
        chk("rst_async_req", 32'(imem_req), 32'd0);
        chk("rst_async_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_mis", 32'(misalign_err), 32'd0);
        chk("rst2_req", 32'(req2), 32'd0);
        chk("rst2_addr", addr2, 32'hFFFF_FFF8);
        chk("rst2_out", {instr2[15:0] | pc2[15:0], 14'd0, valid2, mis2}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle. Drive the inputs, sample at the falling edge, compare
    // against the model, advance the model, and end 1 unit after the rising edge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic e_valid, e_pop, e_req;
        int   occ;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        imem_rdata     = mem_pend ? mem(mem_addr) : 32'($urandom);
        @(negedge clk);
        o_req = imem_req;  o_addr = imem_addr; o_valid = instr_valid;
        o_instr = instr;   o_pc = instr_pc;    o_mis = misalign_err;
        o_req2 = req2;     o_addr2 = addr2;

        e_valid = (q.size() != 0);
        e_pop   = e_valid && rdy && !rv;
        occ     = q.size() + int'(m_infl) - int'(e_pop);
        e_req   = !rv && !m_halt && (occ < DEPTH);
        chk("instr_valid", 32'(o_valid), 32'(e_valid));
        chk("imem_req", 32'(o_req), 32'(e_req));
        chk("imem_addr", o_addr, m_pc);
        chk("misalign_err", 32'(o_mis), 32'(m_mis));
        if (e_valid) begin
            chk("instr", o_instr, q[0].w);
            chk("instr_pc", o_pc, q[0].pc);
        end

        if (rv) begin
            q.delete();
            m_infl = 1'b0;
            m_pc   = rpc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
            m_halt = (rpc[1:0] != 2'b00);
            m_mis  = (rpc[1:0] != 2'b00);
`else
            m_mis  = 1'b0;
`endif
        end else begin
            m_mis = 1'b0;
            if (e_pop)
                void'(q.pop_front());
            if (m_infl)
                q.push_back('{w: mem(m_infl_pc), pc: m_infl_pc});
            m_infl = e_req;
            if (e_req) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
        mem_pend = imem_req;
        mem_addr = imem_addr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        rv, rdy;
        logic [31:0] rpc;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        imem_rdata     = 32'h0;
        model_reset();
        @(posedge clk);
        do_reset();

        // Cold start streaming with ready held high. Also checks PC wrap on the second instance.
        step(1'b0, 32'h0, 1'b1);
        chk("t1_c0_req", 32'(o_req), 32'd1);
        chk("t1_c0_addr", o_addr, 32'h0);
        chk("wrap_c0_addr", o_addr2, 32'hFFFF_FFF8);
        step(1'b0, 32'h0, 1'b1);
        chk("t1_c1_addr", o_addr, 32'h4);
        chk("wrap_c1_addr", o_addr2, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1);
        chk("t1_c2_addr", o_addr, 32'h8);
        chk("wrap_c2_req", 32'(o_req2), 32'd1);
        chk("wrap_c2_addr", o_addr2, 32'h0000_0000);
        chk("t1_c2_valid", 32'(o_valid), 32'd1);
        chk("t1_c2_instr", o_instr, 32'hA5A5_0000);
        chk("t1_c2_pc", o_pc, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        chk("t1_c3_instr", o_instr, 32'hA5A5_0004);
        chk("t1_c3_pc", o_pc, 32'h4);

        // Backpressure: ready low from cycle 2 for 5 cycles.
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0);
            chk("t2_stall_req", 32'(o_req), 32'd0);
            chk("t2_stall_pc", o_pc, 32'h0);
        end
        step(1'b0, 32'h0, 1'b1);
        chk("t2_rel_pc0", o_pc, 32'h0);
        chk("t2_rel_addr", o_addr, 32'h8);
        step(1'b0, 32'h0, 1'b1);
        chk("t2_rel_pc4", o_pc, 32'h4);
        step(1'b0, 32'h0, 1'b1);
        chk("t2_rel_pc8", o_pc, 32'h8);

        // Redirect while a response arrives and a pop is requested.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h100, 1'b1);
        chk("t3_redir_req", 32'(o_req), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("t3_t1_addr", o_addr, 32'h100);
        chk("t3_t1_valid", 32'(o_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("t3_t2_valid", 32'(o_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1);
        chk("t3_t3_pc", o_pc, 32'h100);
        chk("t3_t3_instr", o_instr, 32'hA5A5_0100);
        step(1'b0, 32'h0, 1'b1);
        chk("t3_t4_pc", o_pc, 32'h104);

        // Misaligned redirect.
        step(1'b1, 32'h102, 1'b1);
        step(1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("t4_mis_pulse", 32'(o_mis), 32'd1);
        chk("t4_mis_req", 32'(o_req), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk("t4_halt_req", 32'(o_req), 32'd0);
            chk("t4_halt_mis", 32'(o_mis), 32'd0);
        end
        step(1'b1, 32'h200, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("t4_resume_addr", o_addr, 32'h200);
        chk("t4_resume_req", 32'(o_req), 32'd1);
`else
        chk("t4_mis_zero", 32'(o_mis), 32'd0);
        chk("t4_forced_addr", o_addr, 32'h100);
        chk("t4_forced_req", 32'(o_req), 32'd1);
`endif
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        // Reset mid-stream, with the queue occupied and a request in flight.
        step(1'b0, 32'h0, 1'b0);
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        chk("t5_restart_addr", o_addr, 32'h0);
        chk("t5_restart_req", 32'(o_req), 32'd1);

        // Randomized traffic: random ready, occasional redirects, some misaligned.
        for (int i = 0; i < 600; i++) begin
            rv  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            step(rv, rpc, rdy);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
